// File: rtl/seven_seg_capture_pkg.sv
// rtl/seven_seg_capture_pkg.sv - shared types and glyph table for the seven-segment capture monitor
package seven_seg_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] nib_t;

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}, indexed by hex value
    localparam seg_t SEG_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam int CNT_W = 8;

endpackage

// File: rtl/seven_seg_capture_if.sv
// rtl/seven_seg_capture_if.sv - display bus and capture handshake bundle
interface seven_seg_capture_if;
    import seven_seg_pkg::*;

    seg_t       seg;
    logic [1:0] an;
    logic       pair_ack;
    nib_t       digit0;
    nib_t       digit1;
    logic [1:0] digit_valid;
    logic       pair_valid;
    logic       upd;
    logic       bad;

    modport master (
        output seg, an, pair_ack,
        input  digit0, digit1, digit_valid, pair_valid, upd, bad
    );

    modport slave (
        input  seg, an, pair_ack,
        output digit0, digit1, digit_valid, pair_valid, upd, bad
    );

endinterface

// File: rtl/seven_seg_capture_inv.sv
// rtl/seven_seg_capture_inv.sv - inverse glyph lookup, exact match only
module seven_seg_inv
    import seven_seg_pkg::*;
(
    input  seg_t seg,
    output nib_t value,
    output logic legal
);

    // Compare against every glyph; the table has no duplicates so at most one hits
    always_comb begin
        value = '0;
        legal = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_GLYPH[i]) begin
                value = nib_t'(i);
                legal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_seg_capture.sv
// rtl/seven_seg_capture.sv - stability filter, digit recovery and pair handshake
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter logic ACTIVE_LOW    = 1'b1,
    parameter int   STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    seven_seg_capture_if.slave  bus
);

    localparam logic [CNT_W-1:0] STAB = CNT_W'(STABLE_CYCLES);

    logic [8:0]       samp_q, samp_d;
    logic [8:0]       prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    nib_t             digit0_q, digit0_d;
    nib_t             digit1_q, digit1_d;
    logic [1:0]       dv_q, dv_d;
    logic             pv_q, pv_d;
    logic             upd_q, upd_d;
    logic             bad_q, bad_d;

    logic             capture;
    logic             one_hot;
    nib_t             inv_value;
    logic             inv_legal;

    // The glyph decoded is always the one held in the sample register
    seven_seg_inv u_inv (
        .seg   (samp_q[6:0]),
        .value (inv_value),
        .legal (inv_legal)
    );

    // Next-state: normalise, count stable samples, capture on the edge the count tops out
    always_comb begin
        samp_d   = {bus.an ^ {2{ACTIVE_LOW}}, bus.seg ^ {7{ACTIVE_LOW}}};
        prev_d   = samp_q;
        cnt_d    = cnt_q;
        digit0_d = digit0_q;
        digit1_d = digit1_q;
        upd_d    = 1'b0;
        bad_d    = 1'b0;

        if (samp_q != prev_q) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q < STAB) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Only the STAB-1 -> STAB step fires, so a held pattern captures once
        capture = (cnt_q == STAB - CNT_W'(1)) && (cnt_d == STAB);
        one_hot = (samp_q[8:7] == 2'b01) || (samp_q[8:7] == 2'b10);

        // Ack clears first so a same-edge capture still leaves its own bit set
        dv_d = bus.pair_ack ? 2'b00 : dv_q;

        if (capture && one_hot) begin
            if (inv_legal) begin
                if (samp_q[7]) begin
                    digit0_d = inv_value;
                    dv_d[0]  = 1'b1;
                end else begin
                    digit1_d = inv_value;
                    dv_d[1]  = 1'b1;
                end
                upd_d = 1'b1;
            end else begin
                bad_d = 1'b1;
            end
        end

        pv_d = &dv_d;
    end

    // State register with asynchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            samp_q   <= '0;
            prev_q   <= '0;
            cnt_q    <= '0;
            digit0_q <= '0;
            digit1_q <= '0;
            dv_q     <= '0;
            pv_q     <= 1'b0;
            upd_q    <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            samp_q   <= samp_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            digit0_q <= digit0_d;
            digit1_q <= digit1_d;
            dv_q     <= dv_d;
            pv_q     <= pv_d;
            upd_q    <= upd_d;
            bad_q    <= bad_d;
        end
    end

    assign bus.digit0      = digit0_q;
    assign bus.digit1      = digit1_q;
    assign bus.digit_valid = dv_q;
    assign bus.pair_valid  = pv_q;
    assign bus.upd         = upd_q;
    assign bus.bad         = bad_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// tb/tb_seven_seg_capture.sv - self-checking bench for seven_seg_capture
module tb_seven_seg_capture;

    localparam int S = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    seven_seg_capture_if bus_al ();
    seven_seg_capture_if bus_ah ();

    seven_seg_capture #(.ACTIVE_LOW(1'b1), .STABLE_CYCLES(S)) u_al (
        .clk(clk), .reset_n(reset_n), .bus(bus_al.slave)
    );
    seven_seg_capture #(.ACTIVE_LOW(1'b0), .STABLE_CYCLES(S)) u_ah (
        .clk(clk), .reset_n(reset_n), .bus(bus_ah.slave)
    );

    int n_chk = 0;
    int n_pass = 0;
    int upd_al = 0, bad_al = 0, upd_ah = 0, bad_ah = 0;

    // Reference model state (internal active-high view)
    logic [9:0] m_prev;
    int         m_run;
    logic [3:0] m_d0, m_d1;
    logic [1:0] m_dv;
    logic       m_pv, m_upd, m_bad;

    typedef struct {
        logic [1:0] an_i;
        logic [6:0] lit;
        int         hold;
        logic       ack;
        int         e_upd;
        int         e_bad;
        logic [3:0] e_d0;
        logic [3:0] e_d1;
        logic [1:0] e_dv;
        logic       e_pv;
    } vec_t;

    vec_t vecs [11];

    function automatic logic [6:0] ref_glyph(input int i);
        case (i)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h67; 10: return 7'h77; 11: return 7'h7C;
            12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive_al(input logic [1:0] an_i, input logic [6:0] lit, input logic ack);
        bus_al.an       = ~an_i;
        bus_al.seg      = ~lit;
        bus_al.pair_ack = ack;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus_al.upd) upd_al++;
        if (bus_al.bad) bad_al++;
        if (bus_ah.upd) upd_ah++;
        if (bus_ah.bad) bad_ah++;
    endtask

    // Model: a pattern captures on the edge after it has been sampled S times in a row
    task automatic model_edge(input logic [1:0] an_i, input logic [6:0] lit, input logic ack);
        logic [8:0] cv;
        logic       hit;
        int         val;
        cv    = m_prev[8:0];
        m_upd = 1'b0;
        m_bad = 1'b0;
        if (ack) m_dv = 2'b00;
        if (m_run == S && (cv[8:7] == 2'b01 || cv[8:7] == 2'b10)) begin
            hit = 1'b0;
            val = 0;
            for (int g = 0; g < 16; g++) begin
                if (ref_glyph(g) == cv[6:0]) begin
                    hit = 1'b1;
                    val = g;
                end
            end
            if (hit) begin
                if (cv[7]) begin m_d0 = 4'(val); m_dv[0] = 1'b1; end
                else       begin m_d1 = 4'(val); m_dv[1] = 1'b1; end
                m_upd = 1'b1;
            end else begin
                m_bad = 1'b1;
            end
        end
        m_pv = m_dv[0] & m_dv[1];
        if ({1'b0, an_i, lit} == m_prev) begin
            if (m_run <= S) m_run++;
        end else begin
            m_run = 1;
        end
        m_prev = {1'b0, an_i, lit};
    endtask

    task automatic rand_edge(input logic [1:0] an_i, input logic [6:0] lit, input logic ack);
        logic [12:0] exp_v, act_v;
        drive_al(an_i, lit, ack);
        model_edge(an_i, lit, ack);
        tick();
        exp_v = {m_d1, m_d0, m_dv, m_pv, m_upd, m_bad};
        act_v = {bus_al.digit1, bus_al.digit0, bus_al.digit_valid,
                 bus_al.pair_valid, bus_al.upd, bus_al.bad};
        n_chk++;
        if (act_v == exp_v) n_pass++;
        else $display("FAIL random {d1,d0,dv,pv,upd,bad}: got %h expected %h (in an=%b lit=%h ack=%b)",
                      act_v, exp_v, an_i, lit, ack);
    endtask

    initial begin
        // an_i/lit are internal active-high; drive_al converts to the active-low bus
        vecs[0]  = '{2'b01, 7'h7F, 25, 1'b0, 1, 0, 4'h8, 4'h0, 2'b01, 1'b0};
        vecs[1]  = '{2'b10, 7'h7C,  6, 1'b0, 1, 0, 4'h8, 4'hB, 2'b11, 1'b1};
        vecs[2]  = '{2'b01, 7'h39,  6, 1'b0, 1, 0, 4'hC, 4'hB, 2'b11, 1'b1};
        vecs[3]  = '{2'b01, 7'h39,  1, 1'b1, 0, 0, 4'hC, 4'hB, 2'b00, 1'b0};
        // illegal held exactly S samples: its bad pulse lands on the first edge of the next row
        vecs[4]  = '{2'b01, 7'h7E,  4, 1'b0, 0, 0, 4'hC, 4'hB, 2'b00, 1'b0};
        vecs[5]  = '{2'b00, 7'h7E, 10, 1'b0, 0, 1, 4'hC, 4'hB, 2'b00, 1'b0};
        vecs[6]  = '{2'b00, 7'h00, 10, 1'b0, 0, 0, 4'hC, 4'hB, 2'b00, 1'b0};
        vecs[7]  = '{2'b10, 7'h06,  6, 1'b0, 1, 0, 4'hC, 4'h1, 2'b10, 1'b0};
        vecs[8]  = '{2'b01, 7'h6D,  4, 1'b0, 0, 0, 4'hC, 4'h1, 2'b10, 1'b0};
        vecs[9]  = '{2'b01, 7'h6D,  1, 1'b1, 1, 0, 4'h5, 4'h1, 2'b01, 1'b0};
        vecs[10] = '{2'b11, 7'h3F,  8, 1'b0, 0, 0, 4'h5, 4'h1, 2'b01, 1'b0};

        drive_al(2'b01, 7'h7F, 1'b0);
        bus_ah.an = 2'b00;
        bus_ah.seg = 7'h00;
        bus_ah.pair_ack = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset digit0", int'(bus_al.digit0), 0);
        check("reset digit1", int'(bus_al.digit1), 0);
        check("reset digit_valid", int'(bus_al.digit_valid), 0);
        check("reset pair_valid", int'(bus_al.pair_valid), 0);
        check("reset upd", int'(bus_al.upd), 0);
        check("reset bad", int'(bus_al.bad), 0);
        reset_n = 1'b1;

        for (int v = 0; v < 11; v++) begin
            if (v == 4) begin
                upd_al = 0;
                bad_al = 0;
                for (int r = 0; r < 10; r++) begin
                    drive_al(2'b01, 7'h06, 1'b0);
                    repeat (3) tick();
                    drive_al(2'b01, 7'h5B, 1'b0);
                    repeat (3) tick();
                end
                check("glitch upd", upd_al, 0);
                check("glitch bad", bad_al, 0);
                check("glitch digit0", int'(bus_al.digit0), 12);
                check("glitch digit1", int'(bus_al.digit1), 11);
            end
            upd_al = 0;
            bad_al = 0;
            drive_al(vecs[v].an_i, vecs[v].lit, vecs[v].ack);
            repeat (vecs[v].hold) tick();
            check($sformatf("vec%0d upd", v), upd_al, vecs[v].e_upd);
            check($sformatf("vec%0d bad", v), bad_al, vecs[v].e_bad);
            check($sformatf("vec%0d digit0", v), int'(bus_al.digit0), int'(vecs[v].e_d0));
            check($sformatf("vec%0d digit1", v), int'(bus_al.digit1), int'(vecs[v].e_d1));
            check($sformatf("vec%0d digit_valid", v), int'(bus_al.digit_valid), int'(vecs[v].e_dv));
            check($sformatf("vec%0d pair_valid", v), int'(bus_al.pair_valid), int'(vecs[v].e_pv));
        end
        drive_al(2'b01, 7'h3F, 1'b0);

        // Active-high instance: every glyph on digit 1
        upd_ah = 0;
        bad_ah = 0;
        for (int i = 0; i < 16; i++) begin
            bus_ah.an  = 2'b10;
            bus_ah.seg = ref_glyph(i);
            repeat (6) tick();
            check($sformatf("sweep digit1[%0d]", i), int'(bus_ah.digit1), i);
        end
        check("sweep upd count", upd_ah, 16);
        check("sweep bad count", bad_ah, 0);

        // Reset asserted part-way through a stable period
        drive_al(2'b01, 7'h3F, 1'b0);
        repeat (2) tick();
        #3;
        reset_n = 1'b0;
        #1;
        check("midreset digit0", int'(bus_al.digit0), 0);
        check("midreset digit1", int'(bus_al.digit1), 0);
        check("midreset digit_valid", int'(bus_al.digit_valid), 0);
        check("midreset pair_valid", int'(bus_al.pair_valid), 0);
        check("midreset upd", int'(bus_al.upd), 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        m_prev = 10'h3FF;
        m_run  = 0;
        m_d0   = 4'h0;
        m_d1   = 4'h0;
        m_dv   = 2'b00;
        m_pv   = 1'b0;
        m_upd  = 1'b0;
        m_bad  = 1'b0;
        for (int e = 0; e < 6; e++) rand_edge(2'b01, 7'h3F, 1'b0);
        for (int blk = 0; blk < 150; blk++) begin
            logic [1:0] an_r;
            logic [6:0] lit_r;
            logic [6:0] raw;
            int         hold;
            an_r  = 2'($urandom_range(0, 3));
            raw   = 7'($urandom);
            lit_r = ($urandom_range(0, 3) != 0) ? ref_glyph($urandom_range(0, 15)) : raw;
            hold  = $urandom_range(1, 7);
            for (int h = 0; h < hold; h++) begin
                rand_edge(an_r, lit_r, ($urandom_range(0, 7) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
